// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        PAUSE  = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    // Opcode field value (inst[15:13]) that stops the core.
    localparam logic [2:0] HALT_OPCODE_DEF = 3'b111;

endpackage

// File: rtl/inst_mem.sv
// Instruction store: 2**ADDR_W x INST_W array, synchronous write, asynchronous read.
// Latency: write lands on the next clk edge; read is combinational from raddr.
// Backpressure: none; every write strobe is accepted.
//
// Ports:
//   clk   - rising-edge clock
//   we    - write strobe
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - imem[raddr]
module inst_mem #(
    parameter int ADDR_W = 5,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [INST_W-1:0] rdata
);

    // Contents survive reset by design: there is no reset on the array.
    logic [INST_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC register, imem, LOAD/PAUSE/RUN/HALTED sequencing, retired counter.
// Latency: curr_inst is a combinational read at pc; pc/retired update on the edge after exec_en.
// Backpressure: run=0 pauses (no commit); step rising edges single-step; HALTED stalls until reset.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   load_we/addr/data          - imem write port, honoured only in LOAD
//   load_done                  - leave LOAD
//   run, step                  - free-run level, single-step level (rising edge acts)
//   next_inst_addr             - next PC from the datapath
//   curr_inst, curr_inst_addr  - instruction and PC presented to the datapath
//   exec_en                    - current instruction commits this cycle
//   halted                     - FSM is in HALTED (registered)
//   retired                    - saturating committed-instruction count
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int         ADDR_W      = 5,
    parameter int         INST_W      = 16,
    parameter logic [2:0] HALT_OPCODE = HALT_OPCODE_DEF,
    parameter int         CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [INST_W-1:0] load_data,
    input  logic              load_done,
    input  logic              run,
    input  logic              step,
    input  logic [ADDR_W-1:0] next_inst_addr,
    output logic [INST_W-1:0] curr_inst,
    output logic [ADDR_W-1:0] curr_inst_addr,
    output logic              exec_en,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    fetch_state_t      state_q,   state_d;
    logic [ADDR_W-1:0] pc_q,      pc_d;
    logic              step_q,    step_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              halted_q,  halted_d;

    logic step_rise;
    logic is_halt;
    logic exec_c;
    logic mem_we;

    assign mem_we = (state_q == LOAD) && load_we;

    inst_mem #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_inst_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_q),
        .rdata (curr_inst)
    );

    always_comb begin
        step_d    = step;
        step_rise = step & ~step_q;
        is_halt   = (curr_inst[15:13] == HALT_OPCODE);

        // RUN commits only while run is still high, so the cycle in which run
        // drops does not commit. Reset forces no commit in the reset cycle.
        exec_c = !reset && !is_halt &&
                 ((state_q == RUN && run) || (state_q == PAUSE && step_rise));

        pc_d      = exec_c ? next_inst_addr : pc_q;
        retired_d = (exec_c && (retired_q != {CNT_W{1'b1}})) ?
                    retired_q + CNT_W'(1) : retired_q;

        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (load_done) state_d = PAUSE;
            end
            PAUSE: begin
                if (is_halt && (run || step_rise)) state_d = HALTED;
                else if (run && !is_halt)          state_d = RUN;
            end
            RUN: begin
                // Halt takes priority: the halt instruction never commits.
                if (is_halt)   state_d = HALTED;
                else if (!run) state_d = PAUSE;
            end
            HALTED: state_d = HALTED;
            default: state_d = LOAD;
        endcase

        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOAD;
            pc_q      <= '0;
            step_q    <= 1'b0;
            retired_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            step_q    <= step_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
        end
    end

    assign curr_inst_addr = pc_q;
    assign exec_en        = exec_c;
    assign halted         = halted_q;
    assign retired        = retired_q;

endmodule
